// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the encoder, the decoder and the bench models.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray_f(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

  // Prefix XOR from the MSB down, built by doubling the shift distance.
  function automatic logic [31:0] gray2bin_f(input logic [31:0] value);
    logic [31:0] r_acc;
    r_acc = value;
    r_acc = r_acc ^ (r_acc >> 1);
    r_acc = r_acc ^ (r_acc >> 2);
    r_acc = r_acc ^ (r_acc >> 4);
    r_acc = r_acc ^ (r_acc >> 8);
    r_acc = r_acc ^ (r_acc >> 16);
    return r_acc;
  endfunction

endpackage

// File: rtl/gray_counter_enc_bin2gray.sv
// Combinational binary-to-reflected-Gray XOR network.
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter_enc.sv
// Up/down counter presenting its count in binary and registered Gray code,
// with terminal-count flag and a pulse marking each Gray change.
module gray_counter_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             clr,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             step
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic             r_step;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_active;
  logic             w_tc_next;

  always_comb begin
    w_next   = r_bin;
    w_active = 1'b0;
    if (clr) begin
      w_next   = '0;
      w_active = 1'b1;
    end else if (load) begin
      w_next   = load_bin;
      w_active = 1'b1;
    end else if (en) begin
      w_active = 1'b1;
      if (up) begin
        if ((r_bin == MAX) && !WRAP) w_next = MAX;
        else                         w_next = r_bin + 1'b1;
      end else begin
        if ((r_bin == '0) && !WRAP)  w_next = '0;
        else                         w_next = r_bin - 1'b1;
      end
    end
  end

  // The terminal value depends on the direction sampled this edge, even for clr/load.
  assign w_tc_next = up ? (w_next == MAX) : (w_next == '0);

  bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .i_bin  (w_next),
    .o_gray (w_gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_bin  <= w_next;
      r_gray <= w_gray_next;
      r_step <= (w_gray_next != r_gray);
      if (w_active) r_tc <= w_tc_next;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign tc   = r_tc;
  assign step = r_step;

endmodule

// File: tb/tb_gray_counter_enc.sv
// Bench for gray_counter_enc: a wrapping and a saturating instance driven in lockstep.
module tb_gray_counter_enc;
  import gray_pkg::*;

  localparam int W   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, up, load, clr;
  logic [W-1:0] load_bin;

  logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
  logic         tc_w, step_w, tc_s, step_s;

  gray_counter_enc #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .clr(clr), .bin(bin_w), .gray(gray_w), .tc(tc_w), .step(step_w)
  );

  gray_counter_enc #(.WIDTH(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .clr(clr), .bin(bin_s), .gray(gray_s), .tc(tc_s), .step(step_s)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state, index 0 = wrapping instance, 1 = saturating instance.
  int m_bin [2];
  int m_gray[2];
  int m_tc  [2];
  int m_step[2];

  typedef struct {
    logic         clr, load, en, up;
    logic [W-1:0] lbin;
    logic [W-1:0] exp_bin, exp_gray;
    logic         exp_tc, exp_step;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_next(input int b, input bit wrap);
    if (clr)  return 0;
    if (load) return int'(load_bin);
    if (en) begin
      if (up) return (b == MAXV) ? (wrap ? 0 : MAXV) : b + 1;
      else    return (b == 0)    ? (wrap ? MAXV : 0) : b - 1;
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bin[k] = 0; m_gray[k] = 0; m_tc[k] = 0; m_step[k] = 0;
    end
  endtask

  task automatic check_dut(input int k, input logic [W-1:0] b, input logic [W-1:0] g,
                           input logic t, input logic s);
    string tag;
    tag = (k == 0) ? "wrap" : "sat";
    check({tag, ".bin"},  {28'd0, b}, 32'(m_bin[k]));
    check({tag, ".gray"}, {28'd0, g}, 32'(m_gray[k]));
    check({tag, ".tc"},   {31'd0, t}, 32'(m_tc[k]));
    check({tag, ".step"}, {31'd0, s}, 32'(m_step[k]));
    check({tag, ".decode"}, gray2bin_f({28'd0, g}), {28'd0, b});
  endtask

  // One clock: advance the model from the current inputs, then compare both instances.
  task automatic do_cycle();
    int           nxt;
    int           ng;
    bit           en_only;
    logic [W-1:0] pg_w, pg_s;
    en_only = !clr && !load && en;
    pg_w = gray_w;
    pg_s = gray_s;
    for (int k = 0; k < 2; k++) begin
      nxt = model_next(m_bin[k], (k == 0));
      ng  = int'(bin2gray_f(32'(nxt)));
      m_step[k] = (ng != m_gray[k]) ? 1 : 0;
      if (clr || load || en) m_tc[k] = up ? int'(nxt == MAXV) : int'(nxt == 0);
      m_bin[k]  = nxt;
      m_gray[k] = ng;
    end
    @(posedge clk);
    #1;
    check_dut(0, bin_w, gray_w, tc_w, step_w);
    check_dut(1, bin_s, gray_s, tc_s, step_s);
    if (en_only && (gray_w != pg_w)) check("wrap.onebit", $countones(gray_w ^ pg_w), 1);
    if (en_only && (gray_s != pg_s)) check("sat.onebit",  $countones(gray_s ^ pg_s), 1);
  endtask

  task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                        input logic [W-1:0] lb);
    clr = c; load = l; en = e; up = u; load_bin = lb;
  endtask

  task automatic addv(input logic c, input logic l, input logic e, input logic u,
                      input logic [W-1:0] lb, input logic [W-1:0] eb, input logic [W-1:0] eg,
                      input logic et, input logic es);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.lbin = lb;
    v.exp_bin = eb; v.exp_gray = eg; v.exp_tc = et; v.exp_step = es;
    vecs.push_back(v);
  endtask

  logic [W-1:0] upseq[16];

  initial begin
    upseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    for (int i = 0; i < 16; i++)
      addv(0, 0, 1, 1, '0, 4'((i + 1) % 16), upseq[i], (i == 14), 1'b1);
    addv(0, 0, 1, 0, '0,      4'hF, 4'b1000, 1'b0, 1'b1);
    addv(0, 0, 1, 0, '0,      4'hE, 4'b1001, 1'b0, 1'b1);
    addv(0, 1, 1, 1, 4'b1010, 4'hA, 4'b1111, 1'b0, 1'b1);
    addv(1, 1, 0, 1, 4'b1010, 4'h0, 4'b0000, 1'b0, 1'b1);
    addv(0, 1, 0, 1, 4'b0101, 4'h5, 4'b0111, 1'b0, 1'b1);
    addv(0, 1, 0, 1, 4'b0101, 4'h5, 4'b0111, 1'b0, 1'b0);
    addv(0, 1, 0, 1, 4'b0110, 4'h6, 4'b0101, 1'b0, 1'b1);
    addv(0, 0, 1, 1, '0,      4'h7, 4'b0100, 1'b0, 1'b1);
    addv(0, 0, 1, 0, '0,      4'h6, 4'b0101, 1'b0, 1'b1);
    addv(0, 0, 1, 1, '0,      4'h7, 4'b0100, 1'b0, 1'b1);
    addv(0, 0, 0, 0, '0,      4'h7, 4'b0100, 1'b0, 1'b0);
    addv(0, 1, 0, 0, 4'b0001, 4'h1, 4'b0001, 1'b0, 1'b1);
    addv(0, 0, 1, 0, '0,      4'h0, 4'b0000, 1'b1, 1'b1);
    addv(0, 0, 0, 1, '0,      4'h0, 4'b0000, 1'b1, 1'b0);
    addv(1, 0, 0, 1, '0,      4'h0, 4'b0000, 1'b0, 1'b0);

    // Power-on reset, checked without any clock edge.
    rst_n = 1'b0;
    set_in(0, 0, 0, 1, '0);
    model_reset();
    #2;
    check_dut(0, bin_w, gray_w, tc_w, step_w);
    check_dut(1, bin_s, gray_s, tc_s, step_s);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lbin);
      do_cycle();
      check("tbl.bin",  {28'd0, bin_w},  {28'd0, vecs[i].exp_bin});
      check("tbl.gray", {28'd0, gray_w}, {28'd0, vecs[i].exp_gray});
      check("tbl.tc",   {31'd0, tc_w},   {31'd0, vecs[i].exp_tc});
      check("tbl.step", {31'd0, step_w}, {31'd0, vecs[i].exp_step});
    end

    // Saturation on the non-wrapping instance: reach MAX, then keep pushing up.
    set_in(0, 1, 0, 1, 4'hE);
    do_cycle();
    set_in(0, 0, 1, 1, '0);
    do_cycle();
    check("sat.reach_tc", {31'd0, tc_s}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      check("sat.hold_bin",  {28'd0, bin_s},  32'd15);
      check("sat.hold_gray", {28'd0, gray_s}, 32'b1000);
      check("sat.hold_tc",   {31'd0, tc_s},   32'd1);
      check("sat.hold_step", {31'd0, step_s}, 32'd0);
    end
    set_in(0, 1, 0, 0, 4'h1);
    do_cycle();
    set_in(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) do_cycle();
    check("sat.floor_bin", {28'd0, bin_s}, 32'd0);
    check("sat.floor_step", {31'd0, step_s}, 32'd0);

    // Reset asserted mid-count, away from any clock edge.
    set_in(0, 1, 0, 1, 4'h9);
    do_cycle();
    set_in(0, 0, 1, 1, '0);
    do_cycle();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0, bin_w, gray_w, tc_w, step_w);
    check_dut(1, bin_s, gray_s, tc_s, step_s);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    do_cycle();
    check("rst.resume", {28'd0, bin_w}, 32'd1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
             4'($urandom_range(0, MAXV)));
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
